// File: rtl/gate_sweep_pkg.sv
// Shared constants for the gate sweep unit and its reduction gate.
// Mode codes, FSM encoding and the hold counter width helper.
package gate_sweep_pkg;

    localparam logic [2:0] MODE_OR   = 3'd0;
    localparam logic [2:0] MODE_AND  = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_NAND = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Counter only needs to reach HOLD_CYCLES-1; keep at least one bit.
    function automatic int hold_w(input int hold);
        return (hold <= 1) ? 1 : $clog2(hold);
    endfunction

endpackage

// File: rtl/nway_reduce.sv
// Combinational N-input reduction gate selected by a 3-bit mode.
// Reserved modes evaluate to 0.
module nway_reduce
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [N_IN-1:0] vec,
    input  logic [2:0]      mode,
    output logic            result
);

    always_comb begin
        result = 1'b0;
        case (mode)
            MODE_OR:   result = |vec;
            MODE_AND:  result = &vec;
            MODE_XOR:  result = ^vec;
            MODE_NOR:  result = ~|vec;
            MODE_NAND: result = ~&vec;
            MODE_XNOR: result = ~^vec;
            default:   result = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_unit.sv
// Exhaustive truth-table sweep of an N-input reduction gate.
// Each input value is held HOLD_CYCLES clocks; results held in DONE.
module gate_sweep_unit
    import gate_sweep_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           mode,
    output logic                 busy,
    output logic                 done,
    output logic [N_IN-1:0]      in_vec,
    output logic                 gate_out,
    output logic [(1<<N_IN)-1:0] truth_table,
    output logic [N_IN:0]        ones_count
);

    localparam int HW = hold_w(HOLD_CYCLES);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    logic [1:0]    state;
    logic [2:0]    mode_q;
    logic [HW-1:0] hold_cnt;
    logic          r;

    nway_reduce #(.N_IN(N_IN)) u_reduce (
        .vec    (in_vec),
        .mode   (mode_q),
        .result (r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_q      <= '0;
            hold_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_vec      <= '0;
            gate_out    <= 1'b0;
            truth_table <= '0;
            ones_count  <= '0;
        end else begin
            case (state)
                ST_SWEEP: begin
                    gate_out <= r;
                    if (hold_cnt == HOLD_LAST) begin
                        truth_table[in_vec] <= r;
                        ones_count <= ones_count + {{N_IN{1'b0}}, r};
                        hold_cnt   <= '0;
                        if (in_vec == VEC_LAST) begin
                            state  <= ST_DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            in_vec <= '0;
                        end else begin
                            in_vec <= in_vec + N_IN'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    // IDLE and DONE both wait for start; DONE keeps results
                    gate_out <= 1'b0;
                    if (start) begin
                        state       <= ST_SWEEP;
                        mode_q      <= mode;
                        hold_cnt    <= '0;
                        in_vec      <= '0;
                        truth_table <= '0;
                        ones_count  <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Bench for gate_sweep_unit: four parameterisations, reference model
// derived from gate definitions, directed plus randomized sweeps.
module tb_gate_sweep_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start_v = '0;
    logic [2:0] mode = '0;

    logic [3:0] busy_v, done_v, go_v;
    logic [3:0]   vec0, vec1;
    logic [0:0]   vec2;
    logic [7:0]   vec3;
    logic [15:0]  tt0, tt1;
    logic [1:0]   tt2;
    logic [255:0] tt3;
    logic [4:0]   ones0, ones1;
    logic [1:0]   ones2;
    logic [8:0]   ones3;

    int checks = 0;
    int errors = 0;
    int sel = 0;
    int nv[4] = '{4, 4, 1, 8};
    int hv[4] = '{1, 3, 1, 1};

    logic         busy_s, done_s, go_s;
    logic [7:0]   vec_s;
    logic [255:0] tt_s;
    logic [8:0]   ones_s;

    always #5 clk = ~clk;

    gate_sweep_unit #(.N_IN(4), .HOLD_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode),
        .busy(busy_v[0]), .done(done_v[0]), .in_vec(vec0),
        .gate_out(go_v[0]), .truth_table(tt0), .ones_count(ones0));
    gate_sweep_unit #(.N_IN(4), .HOLD_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode),
        .busy(busy_v[1]), .done(done_v[1]), .in_vec(vec1),
        .gate_out(go_v[1]), .truth_table(tt1), .ones_count(ones1));
    gate_sweep_unit #(.N_IN(1), .HOLD_CYCLES(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode),
        .busy(busy_v[2]), .done(done_v[2]), .in_vec(vec2),
        .gate_out(go_v[2]), .truth_table(tt2), .ones_count(ones2));
    gate_sweep_unit #(.N_IN(8), .HOLD_CYCLES(1)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .mode(mode),
        .busy(busy_v[3]), .done(done_v[3]), .in_vec(vec3),
        .gate_out(go_v[3]), .truth_table(tt3), .ones_count(ones3));

    always_comb begin
        busy_s = busy_v[sel[1:0]];
        done_s = done_v[sel[1:0]];
        go_s   = go_v[sel[1:0]];
        vec_s  = '0;
        tt_s   = '0;
        ones_s = '0;
        case (sel)
            0: begin vec_s = 8'(vec0); tt_s = 256'(tt0); ones_s = 9'(ones0); end
            1: begin vec_s = 8'(vec1); tt_s = 256'(tt1); ones_s = 9'(ones1); end
            2: begin vec_s = 8'(vec2); tt_s = 256'(tt2); ones_s = 9'(ones2); end
            default: begin vec_s = vec3; tt_s = tt3; ones_s = ones3; end
        endcase
    end

    function automatic logic ref_gate(int m, int n, int k);
        logic any_one = (k != 0);
        logic all_one = (k == (1 << n) - 1);
        logic odd     = ($countones(k) % 2) == 1;
        case (m)
            0: return any_one;
            1: return all_one;
            2: return odd;
            3: return !any_one;
            4: return !all_one;
            5: return !odd;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [255:0] ref_tt(int m, int n);
        logic [255:0] t = '0;
        for (int k = 0; k < (1 << n); k++) t[k] = ref_gate(m, n, k);
        return t;
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_busy"}, 256'(busy_s), 256'(0));
        chk({tag, "_done"}, 256'(done_s), 256'(0));
        chk({tag, "_vec"},  256'(vec_s),  256'(0));
        chk({tag, "_go"},   256'(go_s),   256'(0));
        chk({tag, "_tt"},   tt_s,         256'(0));
        chk({tag, "_ones"}, 256'(ones_s), 256'(0));
    endtask

    task automatic run_sweep(int s, int m, int inject_at, bit late_start);
        int n = nv[s];
        int h = hv[s];
        int total = (1 << n) * h;
        logic [255:0] exp_tt = ref_tt(m, n);
        int prev_vec;
        int prev_ones;
        sel = s;
        @(negedge clk);
        mode = 3'(m);
        start_v[s] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        chk("start_busy", 256'(busy_s), 256'(1));
        chk("start_done", 256'(done_s), 256'(0));
        chk("start_tt", tt_s, 256'(0));
        prev_vec = int'(vec_s);
        prev_ones = 0;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            mode = 3'($urandom_range(0, 7));
            if (c == inject_at) start_v[s] = 1'b1;
            if (late_start && c == total) start_v[s] = 1'b1;
            @(posedge clk);
            #1;
            start_v = '0;
            chk("lag", 256'(go_s), 256'(ref_gate(m, n, prev_vec)));
            chk("vec", 256'(vec_s), 256'((c / h) % (1 << n)));
            chk("busy", 256'(busy_s), 256'(c < total));
            chk("done", 256'(done_s), 256'(c == total));
            chk("mono", 256'(int'(ones_s) >= prev_ones), 256'(1));
            prev_vec = int'(vec_s);
            prev_ones = int'(ones_s);
        end
        chk("tt", tt_s, exp_tt);
        chk("ones", 256'(ones_s), 256'($countones(exp_tt)));
        @(posedge clk);
        #1;
        chk("hold_done", 256'(done_s), 256'(1));
        chk("hold_busy", 256'(busy_s), 256'(0));
        chk("done_go", 256'(go_s), 256'(0));
        chk("hold_tt", tt_s, exp_tt);
    endtask

    initial begin
        #2;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check_zero("reset");
        end
        @(negedge clk);
        rst = 1'b0;

        run_sweep(0, 0, 0, 1'b0);
        chk("or_const", tt_s, 256'h0000_FFFE);
        chk("or_ones", 256'(ones_s), 256'(15));
        run_sweep(0, 1, 0, 1'b0);
        chk("and_const", tt_s, 256'h0000_8000);
        run_sweep(0, 2, 0, 1'b0);
        chk("xor_const", tt_s, 256'h0000_6996);
        chk("xor_ones", 256'(ones_s), 256'(8));
        run_sweep(1, 3, 0, 1'b0);
        chk("nor_const", tt_s, 256'h0000_0001);
        run_sweep(0, 0, 5, 1'b0);
        chk("inject_const", tt_s, 256'h0000_FFFE);

        // asynchronous reset partway through a sweep
        sel = 0;
        @(negedge clk);
        mode = 3'd0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v = '0;
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", 256'(busy_s), 256'(0));
        chk("idle_done", 256'(done_s), 256'(0));
        run_sweep(0, 0, 0, 1'b0);

        run_sweep(2, 5, 0, 1'b0);
        chk("xnor1_const", tt_s, 256'h1);
        run_sweep(3, 0, 0, 1'b0);
        chk("or8_ones", 256'(ones_s), 256'(255));
        run_sweep(0, 6, 0, 1'b0);
        run_sweep(0, 7, 0, 1'b0);
        run_sweep(0, 4, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            int s = (i % 3 == 2) ? 1 : (($urandom_range(0, 1) == 0) ? 0 : 2);
            int m = int'($urandom_range(0, 7));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_sweep(s, m, int'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
